// File: rtl/regfile_pkg.sv
// Shared widths and constants for the architectural register file with
// rename tags.
package regfile_pkg;

   localparam int RLEN = 32;
   localparam int RIDX = 5;
   localparam int RBID = 4;
   localparam int NREG = 32;

   localparam logic [RLEN-1:0] null32 = '0;
   localparam logic [RIDX-1:0] null5  = '0;
   localparam logic [RBID-1:0] null4  = '0;

   localparam logic True  = 1'b1;
   localparam logic False = 1'b0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational source-read port: looks up value/busy/tag for rs and
// bypasses a same-cycle commit whose tag matches the pending producer.
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic [RIDX-1:0]      rs,
   input  logic [NREG*RLEN-1:0] val_flat,
   input  logic [NREG-1:0]      busy_vec,
   input  logic [NREG*RBID-1:0] tag_flat,
   input  logic                 write_flag,
   input  logic [RBID-1:0]      write_idx,
   input  logic [RIDX-1:0]      write_rd,
   input  logic [RLEN-1:0]      new_val,
   output logic                 rs_busy,
   output logic [RLEN-1:0]      rs_val,
   output logic [RBID-1:0]      rs_idx
);

   logic [RLEN-1:0] cur_val;
   logic [RBID-1:0] cur_tag;
   logic            cur_busy;
   logic            is_x0;
   logic            hit;

   always_comb begin
      cur_val  = val_flat[int'(rs)*RLEN +: RLEN];
      cur_tag  = tag_flat[int'(rs)*RBID +: RBID];
      cur_busy = busy_vec[rs];
      is_x0    = (rs == null5);
      // Only the commit of the exact pending producer may bypass.
      hit      = write_flag && (write_rd == rs) && (cur_tag == write_idx) && cur_busy;
      rs_busy  = cur_busy && !hit && !is_x0;
      rs_idx   = cur_tag;
      if (is_x0) begin
         rs_val = null32;
      end else if (hit) begin
         rs_val = new_val;
      end else begin
         rs_val = cur_val;
      end
   end

endmodule

// File: rtl/regfile.sv
// Architectural register file: 32 committed values plus busy bit and ROB tag
// per register, fed by the ROB rename (upd_*) and commit (write_*) streams.
module regfile
   import regfile_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            jp_wrong,
   input  logic [RIDX-1:0] rs1,
   input  logic [RIDX-1:0] rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic [RLEN-1:0] reg1,
   output logic [RLEN-1:0] reg2,
   output logic [RBID-1:0] rs1_idx,
   output logic [RBID-1:0] rs2_idx,
   input  logic            upd_flag,
   input  logic [RBID-1:0] upd_idx,
   input  logic [RIDX-1:0] upd_rd,
   input  logic            write_flag,
   input  logic [RBID-1:0] write_idx,
   input  logic [RIDX-1:0] write_rd,
   input  logic [RLEN-1:0] new_val
);

   logic [RLEN-1:0] val_q [NREG];
   logic [RLEN-1:0] val_d [NREG];
   logic [RBID-1:0] tag_q [NREG];
   logic [RBID-1:0] tag_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   logic [NREG*RLEN-1:0] val_flat;
   logic [NREG*RBID-1:0] tag_flat;

   logic do_commit;
   logic do_rename;

   always_comb begin
      val_flat = '0;
      tag_flat = '0;
      for (int r = 0; r < NREG; r++) begin
         val_flat[r*RLEN +: RLEN] = val_q[r];
         tag_flat[r*RBID +: RBID] = tag_q[r];
      end
   end

   always_comb begin
      do_commit = write_flag && (write_rd != null5);
      do_rename = upd_flag && (upd_rd != null5);
      val_d  = val_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      if (jp_wrong) begin
         // Values are committed state and survive a flush; wrong-path commits are dropped.
         busy_d = '0;
         for (int r = 0; r < NREG; r++) begin
            tag_d[r] = null4;
         end
      end else if (rdy) begin
         if (do_commit) begin
            val_d[write_rd] = new_val;
            if (tag_q[write_rd] == write_idx) begin
               busy_d[write_rd] = False;
            end
         end
         // Applied after the commit so a same-register rename wins busy/tag.
         if (do_rename) begin
            busy_d[upd_rd] = True;
            tag_d[upd_rd]  = upd_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         for (int r = 0; r < NREG; r++) begin
            val_q[r] <= null32;
            tag_q[r] <= null4;
         end
      end else begin
         busy_q <= busy_d;
         val_q  <= val_d;
         tag_q  <= tag_d;
      end
   end

   regfile_read_port u_port1 (
      .rs         (rs1),
      .val_flat   (val_flat),
      .busy_vec   (busy_q),
      .tag_flat   (tag_flat),
      .write_flag (write_flag),
      .write_idx  (write_idx),
      .write_rd   (write_rd),
      .new_val    (new_val),
      .rs_busy    (rs1_busy),
      .rs_val     (reg1),
      .rs_idx     (rs1_idx)
   );

   regfile_read_port u_port2 (
      .rs         (rs2),
      .val_flat   (val_flat),
      .busy_vec   (busy_q),
      .tag_flat   (tag_flat),
      .write_flag (write_flag),
      .write_idx  (write_idx),
      .write_rd   (write_rd),
      .new_val    (new_val),
      .rs_busy    (rs2_busy),
      .rs_val     (reg2),
      .rs_idx     (rs2_idx)
   );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: directed scenarios then random traffic,
// checked against an array-based reference model of the register file.
module tb_regfile;

   localparam int PW = 37;
   localparam int W  = 2 * PW;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        jp_wrong;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic [31:0] reg1;
   logic [31:0] reg2;
   logic [3:0]  rs1_idx;
   logic [3:0]  rs2_idx;
   logic        upd_flag;
   logic [3:0]  upd_idx;
   logic [4:0]  upd_rd;
   logic        write_flag;
   logic [3:0]  write_idx;
   logic [4:0]  write_rd;
   logic [31:0] new_val;

   regfile dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .jp_wrong   (jp_wrong),
      .rs1        (rs1),
      .rs2        (rs2),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .reg1       (reg1),
      .reg2       (reg2),
      .rs1_idx    (rs1_idx),
      .rs2_idx    (rs2_idx),
      .upd_flag   (upd_flag),
      .upd_idx    (upd_idx),
      .upd_rd     (upd_rd),
      .write_flag (write_flag),
      .write_idx  (write_idx),
      .write_rd   (write_rd),
      .new_val    (new_val)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, required finish before 1000000");
      $fatal(1, "timeout");
   end

   // reference model
   logic [31:0] m_val  [32];
   logic        m_busy [32];
   logic [3:0]  m_tag  [32];
   bit          model_ok = 1'b0;

   function automatic logic [PW-1:0] model_read(input logic [4:0] rs, input logic wf,
                                                input logic [3:0] wi, input logic [4:0] wr,
                                                input logic [31:0] nv);
      logic        hit;
      logic        b;
      logic [31:0] v;
      hit = wf && (wr == rs) && (m_tag[rs] == wi) && m_busy[rs];
      b   = m_busy[rs] && !hit && (rs != 5'd0);
      if (rs == 5'd0) v = 32'd0;
      else if (hit)   v = nv;
      else            v = m_val[rs];
      return {b, v, m_tag[rs]};
   endfunction

   task automatic model_edge(input logic r, input logic j, input logic y,
                             input logic uf, input logic [3:0] ui, input logic [4:0] ur,
                             input logic wf, input logic [3:0] wi, input logic [4:0] wr,
                             input logic [31:0] nv);
      if (r) begin
         for (int k = 0; k < 32; k++) begin
            m_val[k] = 32'd0; m_busy[k] = 1'b0; m_tag[k] = 4'd0;
         end
      end else if (j) begin
         for (int k = 0; k < 32; k++) begin
            m_busy[k] = 1'b0; m_tag[k] = 4'd0;
         end
      end else if (y) begin
         if (wf && wr != 5'd0) begin
            m_val[wr] = nv;
            if (m_tag[wr] == wi) m_busy[wr] = 1'b0;
         end
         if (uf && ur != 5'd0) begin
            m_busy[ur] = 1'b1;
            m_tag[ur]  = ui;
         end
      end
   endtask

   // scoreboard
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           errors = 0;

   // driver: present one cycle of inputs, queue the expected reads, advance one edge
   task automatic cyc(input string nm, input logic r, input logic j, input logic y,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic uf, input logic [3:0] ui, input logic [4:0] ur,
                      input logic wf, input logic [3:0] wi, input logic [4:0] wr,
                      input logic [31:0] nv);
      rst = r; jp_wrong = j; rdy = y; rs1 = a; rs2 = b;
      upd_flag = uf; upd_idx = ui; upd_rd = ur;
      write_flag = wf; write_idx = wi; write_rd = wr; new_val = nv;
      if (model_ok) begin
         exp_q.push_back({model_read(a, wf, wi, wr, nv), model_read(b, wf, wi, wr, nv)});
         name_q.push_back(nm);
      end
      @(posedge clk);
      model_edge(r, j, y, uf, ui, ur, wf, wi, wr, nv);
      if (r) model_ok = 1'b1;
      #1;
   endtask

   task automatic rd(input string nm, input logic [4:0] a, input logic [4:0] b);
      cyc(nm, 0, 0, 1, a, b, 0, 4'd0, 5'd0, 0, 4'd0, 5'd0, 32'd0);
   endtask

   // monitor: outputs are stable by the falling edge
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [PW-1:0] a1, a2;
      string nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a1 = {rs1_busy, reg1, rs1_idx};
         a2 = {rs2_busy, reg2, rs2_idx};
         checks++;
         if (a1 !== e[W-1:PW]) begin
            errors++;
            $display("FAIL %s port1: actual busy=%0b val=%h idx=%0d required busy=%0b val=%h idx=%0d",
                     nm, a1[36], a1[35:4], a1[3:0], e[73], e[72:41], e[40:37]);
         end
         checks++;
         if (a2 !== e[PW-1:0]) begin
            errors++;
            $display("FAIL %s port2: actual busy=%0b val=%h idx=%0d required busy=%0b val=%h idx=%0d",
                     nm, a2[36], a2[35:4], a2[3:0], e[36], e[35:4], e[3:0]);
         end
      end
   end

   // stimulus
   initial begin
      logic        j, y, uf, wf;
      logic [3:0]  ui, wi;
      logic [4:0]  ur, wr, a, b;
      logic [31:0] nv;

      cyc("reset", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("reset", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rd("reset_read", 5'd5, 5'd0);
      cyc("x0_write", 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'd0, 5'd0, 32'hFFFF_FFFF);
      rd("x0_after", 5'd0, 5'd5);

      cyc("ren_x3", 0, 0, 1, 3, 3, 1, 4'd7, 5'd3, 0, 0, 0, 0);
      rd("x3_busy", 5'd3, 5'd0);
      cyc("x3_bypass", 0, 0, 1, 3, 3, 0, 0, 0, 1, 4'd7, 5'd3, 32'h1234);
      rd("x3_after", 5'd3, 5'd3);

      cyc("ren_x3_2", 0, 0, 1, 3, 0, 1, 4'd2, 5'd3, 0, 0, 0, 0);
      cyc("ren_x3_9", 0, 0, 1, 3, 0, 1, 4'd9, 5'd3, 0, 0, 0, 0);
      cyc("stale_commit", 0, 0, 1, 3, 3, 0, 0, 0, 1, 4'd2, 5'd3, 32'hAA);
      rd("x3_young", 5'd3, 5'd0);

      cyc("commit_ren_x4", 0, 0, 1, 4, 0, 1, 4'd5, 5'd4, 1, 4'd1, 5'd4, 32'h55);
      rd("x4_renamed", 5'd4, 5'd4);
      cyc("x4_commit5", 0, 0, 1, 4, 3, 0, 0, 0, 1, 4'd5, 5'd4, 32'h66);
      rd("x4_done", 5'd4, 5'd0);

      cyc("x2_pre", 0, 0, 1, 2, 0, 0, 0, 0, 1, 4'd0, 5'd2, 32'h77);
      for (int k = 1; k <= 8; k++) begin
         cyc("ren_burst", 0, 0, 1, 5'(k), 5'd2, 1, 4'(k), 5'(k), 0, 0, 0, 0);
      end
      cyc("flush", 0, 1, 1, 2, 1, 0, 0, 0, 1, 4'd2, 5'd2, 32'hDEAD);
      rd("post_flush_a", 5'd2, 5'd1);
      rd("post_flush_b", 5'd8, 5'd5);

      cyc("hold", 0, 0, 0, 6, 5, 1, 4'd3, 5'd6, 1, 4'd0, 5'd5, 32'hBEEF);
      rd("after_hold", 5'd6, 5'd5);
      cyc("enabled", 0, 0, 1, 6, 5, 1, 4'd3, 5'd6, 1, 4'd0, 5'd5, 32'hBEEF);
      rd("after_enable", 5'd6, 5'd5);

      for (int n = 0; n < 2000; n++) begin
         j  = ($urandom_range(0, 39) == 0);
         y  = ($urandom_range(0, 9) != 0);
         uf = $urandom_range(0, 1);
         ui = 4'($urandom_range(0, 15));
         ur = 5'($urandom_range(0, 7));
         wf = $urandom_range(0, 1);
         wr = 5'($urandom_range(0, 7));
         wi = ($urandom_range(0, 1) == 1) ? m_tag[wr] : 4'($urandom_range(0, 15));
         nv = $urandom;
         a  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         b  = 5'($urandom_range(0, 8));
         cyc("random", ($urandom_range(0, 499) == 0), j, y, a, b, uf, ui, ur, wf, wi, wr, nv);
      end

      repeat (2) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file with rename tags for the out-of-order RISC-V core. It holds the 32 committed register values plus a busy bit and an ROB tag per register. It serves the Decoder's two source reads (value, or ROB tag if the register is still pending) and absorbs the ROB's rename (`upd_*`) and commit (`write_*`) streams. It is the receiving end of the ROB→RegFile interface and the source of `rs1_idx`/`rs2_idx` back to the ROB.

## Interface
- No parameters. Widths come from the shared defines: `RLEN` = 32-bit value, `RIDX` = 5-bit register index, `RBID` = 4-bit ROB index (16 entries).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; low freezes all state.
- `jp_wrong` in 1: ROB flush (mispredict); registered in the ROB.
- `rs1`, `rs2` in `RIDX`: Decoder source register numbers.
- `rs1_busy`, `rs2_busy` out 1: source still pending in the ROB.
- `reg1`, `reg2` out `RLEN`: committed (or bypassed) source value.
- `rs1_idx`, `rs2_idx` out `RBID`: ROB tag of the pending producer; to the ROB.
- `upd_flag` in 1: rename a destination register this cycle.
- `upd_idx` in `RBID`: ROB entry that will produce the new value.
- `upd_rd` in `RIDX`: register being renamed.
- `write_flag` in 1: ROB commits a register write this cycle.
- `write_idx` in `RBID`: ROB entry being committed.
- `write_rd` in `RIDX`: destination register of the commit.
- `new_val` in `RLEN`: committed value.

## Operation
- State per register r: `val[r]` (32 bits), `busy[r]` (1 bit), `tag[r]` (4 bits). Register x0 is hard-wired: reads 0, is never busy, and writes/renames to it are dropped.
- Read ports are purely combinational, and each port is independent:
  - `hit` = `write_flag` && `write_rd` == rs && `tag[rs]` == `write_idx` && `busy[rs]`.
  - `rs_busy` = `busy[rs]` && !`hit` && rs != 0.
  - `reg` = `hit` ? `new_val` : `val[rs]`. When rs == 0 the value is 0.
  - `rs_idx` = `tag[rs]`, always driven. It is meaningful only when busy.
  - Reads reflect pre-rename state. An instruction's sources never see its own `upd`, e.g. `addi x1,x1,1`.
- Commit, when `write_flag` && `write_rd` != 0:
  - `val[write_rd]` ← `new_val`.
  - `busy[write_rd]` is cleared only if `tag[write_rd]` == `write_idx`. A younger rename keeps the register busy.
- Rename, when `upd_flag` && `upd_rd` != 0: `busy[upd_rd]` ← 1 and `tag[upd_rd]` ← `upd_idx`.
- Commit and rename to the same rd in the same cycle:
  - The value is written.
  - Busy stays 1 and the tag becomes `upd_idx`.
  - The rename wins on busy/tag.
- Flush, when `jp_wrong` = 1:
  - All `busy` bits clear and all tags reset to 0.
  - `val` is preserved, since it holds committed state only.
  - Commit and rename inputs are ignored in that cycle. Wrong-path entries may present `write_flag` while `jp_wrong` is high.
- Priority order: `rst` > `jp_wrong` > `!rdy` (hold) > commit/rename.

## Timing
- Read latency is 0 cycles (combinational), including the commit bypass.
- Commit and rename become visible in `val`/`busy`/`tag` at the next rising edge.
- Reset values:
  - All `val` = 0, `busy` = 0, `tag` = 0.
  - Outputs then read `rsX_busy` = 0, `regX` = 0, `rsX_idx` = 0.
- A flush takes effect at the edge where `jp_wrong` is sampled high. The next cycle shows every register not busy.
- While `rdy` = 0, outputs still track the current combinational inputs, but no state changes.
- Tag wrap-around: tags are raw ROB indices (mod 16). Because the commit compares on exact tag, a stale commit of an older entry with a reused index cannot occur. The ROB never holds two live entries with the same index.

## Structure
- Shared defines: `RLEN`, `RIDX`, `RBID`, `null32`, `null5`, `null4`, `True`/`False`.
- One natural sub-module, `regfile_read_port`:
  - Inputs: rs, the state vectors, and the commit bus.
  - Outputs: busy/value/tag.
  - Contains the bypass logic and is instantiated twice.
- Main module holds the state arrays and the sequential update logic. Target is about 150–200 lines total.

## Test plan
- Reset, then read x5/x0 → `busy` = 0, `reg` = 0, `idx` = 0. Write x0 via commit with `new_val` = 0xFFFF_FFFF → x0 still reads 0.
- Rename x3 → tag 7, then read x3 → `busy` = 1, `idx` = 7. Commit x3 with idx 7 and `new_val` = 0x1234 → the same cycle bypasses `reg` = 0x1234 with `busy` = 0. After the next edge, x3 reads not busy, 0x1234.
- Rename x3 → 2, then rename x3 → 9, then commit idx 2 with value 0xAA → `val[x3]` = 0xAA, `busy` = 1, `idx` = 9. A read in the commit cycle shows `busy` = 1, since the tag mismatch means no bypass.
- Same cycle: commit x4 (idx 1, value 0x55) and rename x4 → 5 → next cycle x4 reads `busy` = 1, `idx` = 5, and `val` holds 0x55 (check after committing idx 5).
- Rename x1..x8, then assert `jp_wrong` together with `write_flag` for x2 (value 0xDEAD) → next cycle all registers are not busy and x2 retains its pre-flush value (not 0xDEAD).
- Hold `rdy` = 0 while presenting a rename and a commit → no state change. Raise `rdy` → the updates apply on the first enabled edge.
